// File: rtl/efx_add_pipe_if.sv
// efx_add_pipe_if
//   Handshake and data bundle for the pipelined adder/subtractor.
//   master: producer/consumer side (drives operands and out_ready).
//   slave : the adder itself (drives in_ready and the result).
// Signals:
//   in_valid/in_ready  - input handshake
//   a, b               - operands (WIDTH bits)
//   ci                 - carry-in (add) / borrow-in (sub)
//   sub                - 0 = add, 1 = subtract
//   out_valid/out_ready- output handshake
//   o                  - sum/difference (WIDTH bits)
//   co                 - carry-out (add) / not-borrow (sub)
//   ov                 - two's-complement signed overflow
interface efx_add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             co;
  logic             ov;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, o, co, ov
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, o, co, ov
  );
endinterface

// File: rtl/efx_add_pipe.sv
// efx_add_pipe
//   Pipelined carry-chain adder/subtractor. The WIDTH-bit operation is cut
//   into NSEG = WIDTH/SEG_WIDTH segments; stage k resolves segment k using
//   the carry registered by stage k-1. Each stage register carries a whole
//   transaction (valid, partial result, operands, carry), so the pipeline
//   moves as one shift register gated by a single global advance.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - efx_add_pipe_if slave (operands, handshake, result)
module efx_add_pipe #(
  parameter int   WIDTH       = 32,
  parameter int   SEG_WIDTH   = 8,
  parameter logic I0_POLARITY = 1'b1,
  parameter logic I1_POLARITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  efx_add_pipe_if.slave bus
);

  localparam int NSEG = WIDTH / SEG_WIDTH;

  generate
    if ((SEG_WIDTH < 1) || (WIDTH % SEG_WIDTH != 0)) begin : g_bad_width
      $error("efx_add_pipe: WIDTH must be a positive multiple of SEG_WIDTH");
    end
    if ($bits(bus.a) != WIDTH) begin : g_bad_if_width
      $error("efx_add_pipe: interface WIDTH does not match module WIDTH");
    end
  endgenerate

  // Stage registers (index NSEG-1 is the output stage)
  logic [NSEG-1:0]  v_q;
  logic [NSEG-1:0]  c_q;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] r_q [NSEG];

  logic [NSEG-1:0]  v_d;
  logic [NSEG-1:0]  c_d;
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] r_d [NSEG];

  logic             en;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_pol;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipe advances together; no bubble collapsing.
  assign en           = bus.out_ready | ~v_q[NSEG-1];
  assign bus.in_ready = en;

  // Operand conditioning: polarity first, then subtract inversion.
  assign a_eff   = I0_POLARITY ? bus.a : ~bus.a;
  assign b_pol   = I1_POLARITY ? bus.b : ~bus.b;
  assign b_eff   = bus.sub ? ~b_pol : b_pol;
  assign cin_eff = bus.ci ^ bus.sub;

  // Adds segment k of the operands with carry c_src and merges the segment
  // sum into the partial result. Returns {carry_out, merged_result}.
  function automatic logic [WIDTH:0] seg_add(
    input logic [WIDTH-1:0] a_src,
    input logic [WIDTH-1:0] b_src,
    input logic [WIDTH-1:0] r_src,
    input logic             c_src,
    input int               k
  );
    logic [SEG_WIDTH:0] s;
    logic [WIDTH-1:0]   r;
    s = {1'b0, a_src[k*SEG_WIDTH +: SEG_WIDTH]}
      + {1'b0, b_src[k*SEG_WIDTH +: SEG_WIDTH]}
      + {{SEG_WIDTH{1'b0}}, c_src};
    r = r_src;
    r[k*SEG_WIDTH +: SEG_WIDTH] = s[SEG_WIDTH-1:0];
    return {s[SEG_WIDTH], r};
  endfunction

  always_comb begin
    v_d = '0;
    c_d = '0;

    v_d[0]           = bus.in_valid;
    a_d[0]           = a_eff;
    b_d[0]           = b_eff;
    {c_d[0], r_d[0]} = seg_add(a_eff, b_eff, '0, cin_eff, 0);

    for (int k = 1; k < NSEG; k++) begin
      v_d[k]           = v_q[k-1];
      a_d[k]           = a_q[k-1];
      b_d[k]           = b_q[k-1];
      {c_d[k], r_d[k]} = seg_add(a_q[k-1], b_q[k-1], r_q[k-1], c_q[k-1], k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
      end
    end
  end

  assign bus.out_valid = v_q[NSEG-1];
  assign bus.o         = r_q[NSEG-1];
  assign bus.co        = c_q[NSEG-1];

  // Carry into the MSB is a^b^sum at that bit; XOR with carry-out gives
  // signed overflow without keeping a separate register for it.
  assign bus.ov = a_q[NSEG-1][WIDTH-1] ^ b_q[NSEG-1][WIDTH-1]
                ^ r_q[NSEG-1][WIDTH-1] ^ c_q[NSEG-1];

endmodule

// File: tb/tb_efx_add_pipe.sv
// tb_efx_add_pipe
//   Directed bench for efx_add_pipe: reset state, latency, add/subtract
//   corner cases, streaming, backpressure, mid-flight reset, and the
//   inverted-polarity and single-stage configurations.
module tb_efx_add_pipe;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  efx_add_pipe_if #(.WIDTH(32)) bus ();
  efx_add_pipe_if #(.WIDTH(32)) bus_inv ();
  efx_add_pipe_if #(.WIDTH(8))  bus8 ();

  efx_add_pipe #(.WIDTH(32), .SEG_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  efx_add_pipe #(.WIDTH(32), .SEG_WIDTH(8), .I0_POLARITY(1'b0)) dut_inv (
    .clk (clk),
    .rst (rst),
    .bus (bus_inv.slave)
  );

  efx_add_pipe #(.WIDTH(8), .SEG_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.sub      = sub;
  endtask

  // Reference: returns {ov, co, o} for the default-polarity 32-bit adder.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sub);
    logic [31:0] bb;
    logic [32:0] s;
    logic        ovf;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {32'd0, ci ^ sub};
    ovf = (a[31] == bb[31]) && (s[31] != a[31]);
    return {ovf, s[32], s[31:0]};
  endfunction

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        sci [8];
  logic        ssub [8];
  logic [33:0] sexp [8];
  logic [31:0] bpo [5];
  logic [31:0] held;
  int          rcv;

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready     = 1'b0;
    bus_inv.in_valid  = 1'b0;
    bus_inv.a         = '0;
    bus_inv.b         = '0;
    bus_inv.ci        = 1'b0;
    bus_inv.sub       = 1'b0;
    bus_inv.out_ready = 1'b1;
    bus8.in_valid     = 1'b0;
    bus8.a            = '0;
    bus8.b            = '0;
    bus8.ci           = 1'b0;
    bus8.sub          = 1'b0;
    bus8.out_ready    = 1'b1;

    // Reset state; empty pipe is ready even with out_ready=0
    tick();
    tick();
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_o",         {32'd0, bus.o},         64'd0);
    chk("rst_co",        {63'd0, bus.co},        64'd0);
    chk("rst_ov",        {63'd0, bus.ov},        64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    rst = 1'b0;
    tick();
    chk("empty_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;

    // Full carry ripple and 4-edge latency
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("lat_edge0", {63'd0, bus.out_valid}, 64'd0);
    tick();
    chk("lat_edge1", {63'd0, bus.out_valid}, 64'd0);
    tick();
    chk("lat_edge2", {63'd0, bus.out_valid}, 64'd0);
    tick();
    chk("lat_edge3", {63'd0, bus.out_valid}, 64'd1);
    chk("ripple_o",  {32'd0, bus.o},  64'h0000_0000);
    chk("ripple_co", {63'd0, bus.co}, 64'd1);
    chk("ripple_ov", {63'd0, bus.ov}, 64'd0);

    // Subtract cases back-to-back
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'd10, 32'd3, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("sub1_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("sub1_o",  {32'd0, bus.o},  64'hFFFF_FFFE);
    chk("sub1_co", {63'd0, bus.co}, 64'd0);
    chk("sub1_ov", {63'd0, bus.ov}, 64'd0);
    tick();
    chk("sub2_o",  {32'd0, bus.o},  64'h7FFF_FFFF);
    chk("sub2_co", {63'd0, bus.co}, 64'd1);
    chk("sub2_ov", {63'd0, bus.ov}, 64'd1);
    tick();
    chk("sub3_o",  {32'd0, bus.o},  64'd6);
    chk("sub3_co", {63'd0, bus.co}, 64'd1);
    chk("sub3_ov", {63'd0, bus.ov}, 64'd0);

    // Streaming: 8 back-to-back transactions
    for (int i = 0; i < 8; i++) begin
      sa[i]   = $urandom;
      sb[i]   = $urandom;
      sci[i]  = 1'($urandom_range(0, 1));
      ssub[i] = 1'($urandom_range(0, 1));
      sexp[i] = ref_add(sa[i], sb[i], sci[i], ssub[i]);
    end
    rcv = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1'b1, sa[i], sb[i], sci[i], ssub[i]);
      else       drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      chk("stream_valid", {63'd0, bus.out_valid}, {63'd0, (i >= 3) && (i <= 10)});
      if (bus.out_valid && rcv < 8) begin
        chk("stream_o",  {32'd0, bus.o},  {32'd0, sexp[rcv][31:0]});
        chk("stream_co", {63'd0, bus.co}, {63'd0, sexp[rcv][32]});
        chk("stream_ov", {63'd0, bus.ov}, {63'd0, sexp[rcv][33]});
        rcv++;
      end
    end
    chk("stream_count", 64'(rcv), 64'd8);

    // Backpressure: fill, stall 3 cycles, drain
    bpo[0] = 32'd100; bpo[1] = 32'd201; bpo[2] = 32'd302;
    bpo[3] = 32'd403; bpo[4] = 32'd504;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, bpo[j] - 32'd1, 32'd1, 1'b0, 1'b0);
      tick();
    end
    bus.out_ready = 1'b0;
    drive(1'b1, bpo[4] - 32'd1, 32'd1, 1'b0, 1'b0);
    #1;
    chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_first_o",  {32'd0, bus.o}, {32'd0, bpo[0]});
    held = bus.o;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("bp_stall_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_stall_ready", {63'd0, bus.in_ready},  64'd0);
      chk("bp_stall_o",     {32'd0, bus.o},         {32'd0, bpo[0]});
    end
    chk("bp_held_stable", {32'd0, bus.o}, {32'd0, held});
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int j = 1; j < 5; j++) begin
      chk("bp_drain_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_drain_o",     {32'd0, bus.o},         {32'd0, bpo[j]});
      tick();
    end
    chk("bp_drain_empty", {63'd0, bus.out_valid}, 64'd0);

    // Reset with three transactions in flight
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'd1000 + 32'(j), 32'd1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("mid_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("mid_pre_o",     {32'd0, bus.o},         64'd1001);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_o",     {32'd0, bus.o},         64'd0);
    tick();
    chk("mid_rst_hold", {63'd0, bus.out_valid}, 64'd0);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("mid_no_stale", {63'd0, bus.out_valid}, 64'd0);
    end

    // Inverted A polarity and single-stage 8-bit configuration
    bus_inv.in_valid = 1'b1;
    bus_inv.a = 32'd0;
    bus_inv.b = 32'd0;
    bus_inv.ci = 1'b0;
    bus_inv.sub = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.a = 8'h7F;
    bus8.b = 8'h01;
    tick();
    bus_inv.in_valid = 1'b0;
    chk("w8_lat1_valid", {63'd0, bus8.out_valid}, 64'd1);
    chk("w8_o",  {56'd0, bus8.o},  64'h80);
    chk("w8_ov", {63'd0, bus8.ov}, 64'd1);
    chk("w8_co", {63'd0, bus8.co}, 64'd0);
    bus8.a = 8'hFF;
    bus8.b = 8'h01;
    tick();
    bus8.in_valid = 1'b0;
    chk("w8_wrap_o",  {56'd0, bus8.o},  64'h00);
    chk("w8_wrap_co", {63'd0, bus8.co}, 64'd1);
    chk("w8_wrap_ov", {63'd0, bus8.ov}, 64'd0);
    tick();
    chk("w8_empty", {63'd0, bus8.out_valid}, 64'd0);
    tick();
    chk("inv_valid", {63'd0, bus_inv.out_valid}, 64'd1);
    chk("inv_o",     {32'd0, bus_inv.o},         64'hFFFF_FFFF);
    chk("inv_co",    {63'd0, bus_inv.co},        64'd0);
    chk("inv_ov",    {63'd0, bus_inv.ov},        64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/efx_add_pipe.md
# efx_add_pipe

Parametrised, pipelined carry-chain adder/subtractor, the multi-bit successor to the single-bit full-adder primitive. The WIDTH-bit operation is split into SEG_WIDTH-bit segments, and one segment's carry is resolved per pipeline stage, so timing closes at high clock rates on wide datapaths. It sits between datapath producers (ALU operand muxes, address generators) and consumers, and uses a valid/ready handshake with full backpressure. Per-operand programmable inversion is kept; per-transaction subtract mode and signed-overflow detection are added.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEG_WIDTH (elaboration error otherwise).
- SEG_WIDTH, 8: bits resolved per pipeline stage; NSEG = WIDTH/SEG_WIDTH stages.
- I0_POLARITY, 1'b1: 0 inverts A before use.
- I1_POLARITY, 1'b1: 0 inverts B before use (applied before SUB inversion).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input transaction present.
- IN_READY  out  1  block accepts input this cycle.
- A  in  WIDTH  operand 0.
- B  in  WIDTH  operand 1.
- CI  in  1  carry-in (add) / borrow-in (sub).
- SUB  in  1  0 = add, 1 = subtract.
- OUT_VALID  out  1  result present.
- OUT_READY  in  1  consumer takes result.
- O  out  WIDTH  sum/difference.
- CO  out  1  carry-out (add) / not-borrow (sub).
- OV  out  1  two's-complement signed overflow.

## Operation
- Effective operands: a = I0_POLARITY ? A : ~A; b0 = I1_POLARITY ? B : ~B; b = SUB ? ~b0 : b0; cin = CI ^ SUB.
- Result: {CO, O} = a + b + cin, modulo 2^(WIDTH+1).
- SUB=1, CI=0 gives A−B. SUB=1, CI=1 gives A−B−1 (borrow chaining).
- OV = carry into MSB XOR carry out of MSB.
- Stage k (0..NSEG−1) adds segment k of a and b with the carry registered by stage k−1; stage 0 uses cin.
- Lower result segments and upper operand segments are skew-registered alongside, so each stage holds one complete transaction.
- Each stage register holds a valid bit, partial result, remaining operand bits and carry.
- Global advance: EN = OUT_READY | ~OUT_VALID. All stages shift only when EN=1; no bubble collapsing.
- IN_READY = EN, combinational. A transaction is accepted when IN_VALID & IN_READY at a rising edge.
- When EN=1 and IN_VALID=0, a bubble (valid=0) enters stage 0.
- OUT_VALID, O, CO and OV come from the final stage register.
- Data registers of invalid stages may hold any value. O, CO and OV are only meaningful while OUT_VALID=1.
- NSEG=1: a single registered stage, equivalent to a registered full-width adder.

## Timing
- Reset (async assert, sync deassert expected): all stage valids=0, all data regs=0. OUT_VALID=0, O=0, CO=0, OV=0, IN_READY=1.
- Latency: a result accepted at edge t appears with OUT_VALID=1 after edge t+NSEG−1 (NSEG register stages).
- Throughput: 1 transaction/cycle while OUT_READY=1.
- Stall: OUT_VALID=1 & OUT_READY=0 makes IN_READY=0. All stages then hold and O/CO/OV stay stable. Nothing is lost or duplicated.
- Stall release: the pipeline resumes on the first edge with OUT_READY=1. The held result is consumed on that edge.
- Empty pipeline: OUT_VALID=0, so IN_READY=1 regardless of OUT_READY.
- Reset mid-operation: all in-flight transactions are discarded immediately; OUT_VALID=0 while RST is high.
- Wrap-around: arithmetic wraps modulo 2^WIDTH; overflow is reported only through CO/OV.

## Test plan
- Add with full carry ripple: A=0xFFFFFFFF, B=1, CI=0, SUB=0 → after 4 cycles O=0x00000000, CO=1, OV=0.
- Subtract: A=5, B=7, SUB=1, CI=0 → O=0xFFFFFFFE, CO=0, OV=0. A=0x80000000, B=1, SUB=1 → O=0x7FFFFFFF, CO=1, OV=1.
- Streaming: 8 back-to-back random transactions, OUT_READY=1 → 8 consecutive results starting 4 cycles later, matching the reference model in order.
- Backpressure: fill the pipe, then OUT_READY=0 for 3 cycles → IN_READY=0, O held constant, then the remaining results drain in order with no loss or duplicates.
- Reset mid-flight: assert RST with 3 transactions in flight → OUT_VALID=0 immediately, and no stale results appear after release.
- Configs: I0_POLARITY=0, A=0, B=0, CI=0 → O=0xFFFFFFFF. WIDTH=8, SEG_WIDTH=8 → latency 1, 0x7F+0x01 gives O=0x80, OV=1.
